mem_port_arbiter: RTL and testbench

// - Shares one single-ported unified memory between IF-stage fetch and MEM-stage load/store.
// - Sits between the pipeline stages and the memory. Owns a request/ready handshake to the

---
 rtl/pipeline_pkg.sv | 20 ++
 rtl/mem_port_watchdog.sv | 28 ++
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and width defaults for the unified-memory port arbiter.
package pipeline_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int STARVE_W   = 4;   // holds STARVE_LIMIT up to 15
  localparam int WD_W       = 8;   // holds TIMEOUT up to 255

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_watchdog.sv
// Watchdog for a pending memory access: counts cycles spent waiting for PortReady
// and flags expiry on the TIMEOUT-th waiting cycle.
module mem_port_watchdog
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT = 16
)(
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [WD_W-1:0] r_cnt;

  // r_cnt holds the number of waiting cycles already elapsed, so the current
  // waiting cycle is the last one allowed when r_cnt == TIMEOUT-1.
  assign o_expire = i_en & (r_cnt == WD_W'(TIMEOUT - 1));

  // Wait-cycle counter; restarts on every new grant and on expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               r_cnt <= '0;
    else if (i_clr || o_expire) r_cnt <= '0;
    else if (i_en)              r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between IF fetch and MEM load/store, with an IF
// starvation limit and a watchdog that aborts accesses the memory never answers.
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
)(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              IfReq,
  input  logic [ADDR_W-1:0] IfAddr,
  output logic [DATA_W-1:0] IfRdata,
  output logic              IfValid,
  output logic              IfStall,
  input  logic              DmReq,
  input  logic              DmWe,
  input  logic [ADDR_W-1:0] DmAddr,
  input  logic [DATA_W-1:0] DmWdata,
  output logic [DATA_W-1:0] DmRdata,
  output logic              DmValid,
  output logic              DmStall,
  output logic              PortReq,
  output logic              PortWe,
  output logic [ADDR_W-1:0] PortAddr,
  output logic [DATA_W-1:0] PortWdata,
  input  logic              PortReady,
  input  logic [DATA_W-1:0] PortRdata,
  output logic              ErrTimeout
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_t          r_state, w_state_nxt;
  logic [STARVE_W-1:0] r_starve;
  owner_t              w_owner;
  logic                w_busy, w_done, w_arb, w_expire;
  logic                w_gnt_if, w_gnt_dm;

  assign w_busy  = (r_state != IDLE);
  assign w_done  = w_busy & PortReady;
  // Arbitrate when free, or in the completion cycle so a new grant follows with no gap.
  assign w_arb   = ~w_busy | w_done;
  assign w_owner = (r_state == BUSY_D) ? OWN_DM : OWN_IF;

  assign IfStall = IfReq & ~IfValid;
  assign DmStall = DmReq & ~DmValid;

  mem_port_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_arb),
    .i_en     (w_busy & ~PortReady),
    .o_expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Grant selection and next state: data wins unless IF has waited out the starve limit.
  always_comb begin
    w_gnt_if    = 1'b0;
    w_gnt_dm    = 1'b0;
    w_state_nxt = r_state;
    if (w_arb) begin
      if (DmReq && (!IfReq || r_starve != STARVE_MAX)) w_gnt_dm = 1'b1;
      else if (IfReq)                                  w_gnt_if = 1'b1;
    end
    if (w_gnt_dm)              w_state_nxt = BUSY_D;
    else if (w_gnt_if)         w_state_nxt = BUSY_I;
    else if (w_arb || w_expire) w_state_nxt = IDLE;
  end

  // Starve counter: consecutive data grants that beat a waiting fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_starve <= '0;
    else if (w_gnt_if) r_starve <= '0;
    else if (w_gnt_dm) begin
      if (!IfReq)                    r_starve <= '0;
      else if (r_starve != STARVE_MAX) r_starve <= r_starve + 1'b1;
    end
  end

  // Memory port registers: loaded on grant, held for the whole access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      PortReq   <= 1'b0;
      PortWe    <= 1'b0;
      PortAddr  <= '0;
      PortWdata <= '0;
    end else if (w_gnt_dm) begin
      PortReq   <= 1'b1;
      PortWe    <= DmWe;
      PortAddr  <= DmAddr;
      PortWdata <= DmWdata;
    end else if (w_gnt_if) begin
      PortReq   <= 1'b1;
      PortWe    <= 1'b0;
      PortAddr  <= IfAddr;
      PortWdata <= '0;
    end else if (w_arb || w_expire) begin
      PortReq   <= 1'b0;
      PortWe    <= 1'b0;
    end
  end

  // Completion: return load data (zero for stores and aborts) and pulse the owner's Valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      IfValid <= 1'b0;
      DmValid <= 1'b0;
      IfRdata <= '0;
      DmRdata <= '0;
    end else begin
      IfValid <= 1'b0;
      DmValid <= 1'b0;
      if (w_done || w_expire) begin
        if (w_owner == OWN_DM) begin
          DmValid <= 1'b1;
          DmRdata <= (w_done && !PortWe) ? PortRdata : '0;
        end else begin
          IfValid <= 1'b1;
          IfRdata <= w_done ? PortRdata : '0;
        end
      end
    end
  end

  // Sticky watchdog error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      ErrTimeout <= 1'b0;
    else if (w_expire) ErrTimeout <= 1'b1;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, plus hand-computed checks on the directed scenarios.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          IfReq, DmReq, DmWe, PortReady;
  logic [AW-1:0] IfAddr, DmAddr;
  logic [DW-1:0] DmWdata, PortRdata;
  logic [DW-1:0] IfRdata, DmRdata, PortWdata;
  logic [AW-1:0] PortAddr;
  logic          IfValid, IfStall, DmValid, DmStall, PortReq, PortWe, ErrTimeout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfRdata(IfRdata), .IfValid(IfValid), .IfStall(IfStall),
    .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmWdata(DmWdata),
    .DmRdata(DmRdata), .DmValid(DmValid), .DmStall(DmStall),
    .PortReq(PortReq), .PortWe(PortWe), .PortAddr(PortAddr), .PortWdata(PortWdata),
    .PortReady(PortReady), .PortRdata(PortRdata), .ErrTimeout(ErrTimeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one access in flight at most) ----------------
  typedef struct packed {
    bit          own_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  bit          m_busy, m_if_valid, m_dm_valid, m_err;
  txn_t        m_cur;
  int          m_wait, m_starve;
  logic [31:0] m_if_rdata, m_dm_rdata;

  always @(posedge clk or negedge reset_n) begin
    bit free;
    if (!reset_n) begin
      m_busy = 0; m_if_valid = 0; m_dm_valid = 0; m_err = 0;
      m_cur = '0; m_wait = 0; m_starve = 0;
      m_if_rdata = '0; m_dm_rdata = '0;
    end else begin
      free = !m_busy;
      m_if_valid = 0;
      m_dm_valid = 0;
      if (m_busy) begin
        if (PortReady) begin
          if (m_cur.own_dm) begin m_dm_valid = 1; m_dm_rdata = m_cur.we ? 32'h0 : PortRdata; end
          else              begin m_if_valid = 1; m_if_rdata = PortRdata; end
          m_busy = 0;
          free = 1;
        end else begin
          m_wait++;
          if (m_wait == TIMEOUT) begin
            if (m_cur.own_dm) begin m_dm_valid = 1; m_dm_rdata = '0; end
            else              begin m_if_valid = 1; m_if_rdata = '0; end
            m_err = 1;
            m_busy = 0;
          end
        end
      end
      if (free) begin
        if (DmReq && (!IfReq || m_starve < STARVE_LIMIT)) begin
          m_cur = '{own_dm: 1'b1, we: DmWe, addr: DmAddr, wdata: DmWdata};
          m_busy = 1; m_wait = 0;
          m_starve = IfReq ? ((m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1) : 0;
        end else if (IfReq) begin
          m_cur = '{own_dm: 1'b0, we: 1'b0, addr: IfAddr, wdata: 32'h0};
          m_busy = 1; m_wait = 0;
          m_starve = 0;
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  always @(posedge clk) begin
    #1;
    chk("PortReq", 32'(PortReq), 32'(m_busy));
    if (m_busy) begin
      chk("PortWe", 32'(PortWe), 32'(m_cur.we));
      chk("PortAddr", PortAddr, m_cur.addr);
      if (m_cur.we) chk("PortWdata", PortWdata, m_cur.wdata);
    end
    chk("IfValid", 32'(IfValid), 32'(m_if_valid));
    chk("DmValid", 32'(DmValid), 32'(m_dm_valid));
    chk("IfRdata", IfRdata, m_if_rdata);
    chk("DmRdata", DmRdata, m_dm_rdata);
    chk("ErrTimeout", 32'(ErrTimeout), 32'(m_err));
    chk("IfStall", 32'(IfStall), 32'(IfReq & ~m_if_valid));
    chk("DmStall", 32'(DmStall), 32'(DmReq & ~m_dm_valid));
  end

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    logic [9:0] seq;
    reset_n = 0; IfReq = 0; DmReq = 0; DmWe = 0; PortReady = 0;
    IfAddr = '0; DmAddr = '0; DmWdata = '0; PortRdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_PortReq", 32'(PortReq), 32'h0);
    chk("rst_IfValid", 32'(IfValid), 32'h0);
    chk("rst_Err", 32'(ErrTimeout), 32'h0);
    chk("rst_IfRdata", IfRdata, 32'h0);
    reset_n = 1;
    @(negedge clk);

    // 1: fetch only, memory answers on the third PortReq cycle
    IfReq = 1; IfAddr = 32'h0040_0000;
    @(negedge clk);
    chk("t1_PortReq", 32'(PortReq), 32'h1);
    chk("t1_PortAddr", PortAddr, 32'h0040_0000);
    @(negedge clk);
    chk("t1_IfStall", 32'(IfStall), 32'h1);
    @(negedge clk);
    PortReady = 1; PortRdata = 32'h2408_0005; IfReq = 0;
    @(negedge clk);
    PortReady = 0;
    chk("t1_IfValid", 32'(IfValid), 32'h1);
    chk("t1_IfRdata", IfRdata, 32'h2408_0005);
    chk("t1_PortReq_off", 32'(PortReq), 32'h0);
    @(negedge clk);
    chk("t1_IfValid_pulse", 32'(IfValid), 32'h0);
    chk("t1_IfRdata_hold", IfRdata, 32'h2408_0005);

    // 2: simultaneous store and fetch -> store first, fetch back-to-back
    IfReq = 1; IfAddr = 32'h0040_0004;
    DmReq = 1; DmWe = 1; DmAddr = 32'h1001_0000; DmWdata = 32'h1234_5678;
    @(negedge clk);
    chk("t2_PortWe", 32'(PortWe), 32'h1);
    chk("t2_PortAddr", PortAddr, 32'h1001_0000);
    chk("t2_PortWdata", PortWdata, 32'h1234_5678);
    PortReady = 1; PortRdata = 32'hDEAD_BEEF; DmReq = 0;
    @(negedge clk);
    chk("t2_DmValid", 32'(DmValid), 32'h1);
    chk("t2_DmRdata_store", DmRdata, 32'h0);
    chk("t2_btb_PortReq", 32'(PortReq), 32'h1);
    chk("t2_btb_PortAddr", PortAddr, 32'h0040_0004);
    chk("t2_btb_PortWe", 32'(PortWe), 32'h0);
    PortRdata = 32'h1111_2222; IfReq = 0; DmWe = 0;
    @(negedge clk);
    PortReady = 0;
    chk("t2_IfValid", 32'(IfValid), 32'h1);
    chk("t2_IfRdata", IfRdata, 32'h1111_2222);
    @(negedge clk);

    // 3: both held, memory ready every cycle -> DDDDI repeating
    IfReq = 1; IfAddr = 32'h0040_0008;
    DmReq = 1; DmWe = 0; DmAddr = 32'h1001_0004;
    PortReady = 1; PortRdata = 32'hA000_0000;
    seq = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t3_PortReq", 32'(PortReq), 32'h1);
      seq[k] = (PortAddr == 32'h0040_0008);
      PortRdata = PortRdata + 32'h1;
    end
    chk("t3_grant_seq", 32'(seq), 32'(10'b1000010000));
    IfReq = 0; DmReq = 0;
    @(negedge clk);
    PortReady = 0;
    @(negedge clk);

    // 6: ready arrives in the very cycle the watchdog would expire
    DmReq = 1; DmWe = 0; DmAddr = 32'h1001_0008;
    repeat (16) @(negedge clk);
    chk("t6_PortReq_16", 32'(PortReq), 32'h1);
    PortReady = 1; PortRdata = 32'hCAFE_F00D; DmReq = 0;
    @(negedge clk);
    PortReady = 0;
    chk("t6_DmValid", 32'(DmValid), 32'h1);
    chk("t6_DmRdata", DmRdata, 32'hCAFE_F00D);
    chk("t6_Err", 32'(ErrTimeout), 32'h0);
    @(negedge clk);

    // 4: memory never answers -> abort after 16 PortReq cycles
    DmReq = 1; DmWe = 0; DmAddr = 32'h1001_000C;
    repeat (16) @(negedge clk);
    chk("t4_PortReq_16", 32'(PortReq), 32'h1);
    @(negedge clk);
    DmReq = 0;
    chk("t4_PortReq_drop", 32'(PortReq), 32'h0);
    chk("t4_DmValid", 32'(DmValid), 32'h1);
    chk("t4_DmRdata", DmRdata, 32'h0);
    chk("t4_Err", 32'(ErrTimeout), 32'h1);
    repeat (3) @(negedge clk);
    chk("t4_Err_sticky", 32'(ErrTimeout), 32'h1);
    chk("t4_PortReq_idle", 32'(PortReq), 32'h0);

    // 5: reset during BUSY_D with PortReady pending, late PortReady after release
    DmReq = 1; DmWe = 0; DmAddr = 32'h1001_0010;
    @(negedge clk);
    chk("t5_PortReq", 32'(PortReq), 32'h1);
    PortReady = 1; PortRdata = 32'h5555_AAAA; DmReq = 0;
    reset_n = 0;
    #1;
    chk("t5_rst_PortReq", 32'(PortReq), 32'h0);
    chk("t5_rst_PortAddr", PortAddr, 32'h0);
    chk("t5_rst_Err", 32'(ErrTimeout), 32'h0);
    chk("t5_rst_IfRdata", IfRdata, 32'h0);
    chk("t5_rst_DmValid", 32'(DmValid), 32'h0);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("t5_late_DmValid", 32'(DmValid), 32'h0);
    chk("t5_late_DmRdata", DmRdata, 32'h0);
    @(negedge clk);
    PortReady = 0;
    chk("t5_late_DmValid2", 32'(DmValid), 32'h0);
    chk("t5_late_PortReq", 32'(PortReq), 32'h0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
